// File: rtl/i2c_init_pkg.sv
// i2c_init_pkg: constants shared by the AK4619 power-up I2C sequencer.
//   - codec write-address byte
//   - 17-entry sequence ROM: transaction 1 (14 bytes) followed by
//     transaction 2 (3 bytes)
//   - per-transaction byte counts
//   - sequencer state enum
package i2c_init_pkg;

  localparam logic [7:0] CODEC_ADDR_WR = 8'h20;  // 7-bit address 0x10, R/W=0

  localparam int TXN1_BYTES = 14;
  localparam int TXN2_BYTES = 3;
  localparam int SEQ_LEN    = TXN1_BYTES + TXN2_BYTES;

  // Transaction 1 programs registers 0x00-0x0B via auto-increment;
  // transaction 2 rewrites register 0x00 to release the ADC/DAC resets.
  localparam logic [7:0] SEQ_ROM [0:SEQ_LEN-1] = '{
    CODEC_ADDR_WR, 8'h00,
    8'h36, 8'hAE, 8'h1C, 8'h01, 8'h22, 8'h22,
    8'h30, 8'h30, 8'h30, 8'h30, 8'h22, 8'h00,
    CODEC_ADDR_WR, 8'h00, 8'h37
  };

  typedef enum logic [2:0] {
    ST_DELAY,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/i2c_init_byte_tx.sv
// i2c_byte_tx: serialises one byte plus a released ACK bit as a
// 36-cycle SCL/SDA pattern (9 bits x 4 cycles, MSB first).
//   clk, rst     clock, synchronous active-high reset
//   go_i         start a new byte; its first cycle is produced this edge
//   byte_i       byte to send, sampled when go_i is high
//   scl_o/sda_o  line values for the cycle being produced at this edge
//                (combinational; the parent registers them)
//   byte_done_o  one-cycle pulse the cycle after the last (ACK) cycle
module i2c_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       byte_done_o
);

  logic       active_q;
  logic [3:0] bit_q;
  logic [1:0] ph_q;
  logic [7:0] shreg_q;
  logic       done_q;

  logic [3:0] cur_bit;
  logic [1:0] cur_ph;
  logic       cur_msb;

  // go_i restarts at bit 0 / phase 0 in the same edge, so the next byte
  // follows the previous one with no idle cycle in between.
  assign cur_bit = go_i ? 4'd0 : bit_q;
  assign cur_ph  = go_i ? 2'd0 : ph_q;
  assign cur_msb = go_i ? byte_i[7] : shreg_q[7];

  assign scl_o       = (cur_ph == 2'd1) || (cur_ph == 2'd2);
  assign sda_o       = (cur_bit == 4'd8) ? 1'b1 : cur_msb;  // ACK slot released
  assign byte_done_o = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      ph_q     <= '0;
      shreg_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go_i) begin
        active_q <= 1'b1;
        shreg_q  <= byte_i;
        bit_q    <= '0;
        ph_q     <= 2'd1;
      end else if (active_q) begin
        ph_q <= ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          shreg_q <= {shreg_q[6:0], 1'b0};
          if (bit_q == 4'd8) begin
            active_q <= 1'b0;
            bit_q    <= '0;
            done_q   <= 1'b1;
          end else begin
            bit_q <= bit_q + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/i2c_init.sv
// i2c_init: power-up I2C configuration sequencer for the AK4619 codec.
// After reset it writes the two transactions held in SEQ_ROM, then idles
// with both lines released and done high.
//   clk      sequencer clock (LRCK frame clock)
//   rst      synchronous active-high reset; aborts and restarts everything
//   scl      SCL drive, 1 = release, 0 = pull low (registered)
//   sda_out  SDA drive, 1 = release, 0 = pull low (registered)
//   done     high once both transactions have completed (registered)
// Build option: I2C_INIT_STARTUP_DELAY_EN holds the bus idle for
// STARTUP_CYCLES cycles before the first START; otherwise START follows
// reset release directly and STARTUP_CYCLES only sizes the phase counter.
module i2c_init
  import i2c_init_pkg::*;
#(
  parameter int STARTUP_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  output logic scl,
  output logic sda_out,
  output logic done
);

  localparam int CW = (STARTUP_CYCLES > 4) ? $clog2(STARTUP_CYCLES) : 2;

`ifdef I2C_INIT_STARTUP_DELAY_EN
  localparam state_e RST_STATE = ST_DELAY;
`else
  localparam state_e RST_STATE = ST_START;
`endif

  // state_q/cnt_q name the bus cycle that the next edge will produce.
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    idx_q;   // next ROM entry to send
  logic [3:0]    rem_q;   // bytes still to start in this transaction
  logic          txn_q;   // 0 = register block write, 1 = reset release
  logic          scl_q, sda_q, done_q;

  logic go, tx_scl, tx_sda, tx_done;

  // In BYTE, cnt_q==0 marks the first byte after START; later bytes are
  // launched back-to-back off byte_done.
  assign go = (state_q == ST_BYTE) &&
              ((cnt_q == '0) || (tx_done && (rem_q != 4'd0)));

  i2c_byte_tx u_tx (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go),
    .byte_i     (SEQ_ROM[idx_q]),
    .scl_o      (tx_scl),
    .sda_o      (tx_sda),
    .byte_done_o(tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      txn_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_DELAY: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_START: begin
          scl_q <= (cnt_q != CW'(2));
          sda_q <= (cnt_q == CW'(0));
          if (cnt_q == CW'(2)) begin
            state_q <= ST_BYTE;
            cnt_q   <= '0;
            rem_q   <= txn_q ? 4'(TXN2_BYTES) : 4'(TXN1_BYTES);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_BYTE: begin
          if (tx_done && (rem_q == 4'd0)) begin
            // First STOP cycle is produced here so it abuts the ACK bit.
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            state_q <= ST_STOP;
            cnt_q   <= CW'(1);
          end else begin
            scl_q <= tx_scl;
            sda_q <= tx_sda;
          end
          if (go) begin
            cnt_q <= CW'(1);
            rem_q <= rem_q - 4'd1;
            idx_q <= (idx_q == 5'(SEQ_LEN - 1)) ? 5'd0 : idx_q + 5'd1;
          end
        end
        ST_STOP: begin
          scl_q <= 1'b1;
          sda_q <= (cnt_q == CW'(2));
          if (cnt_q == CW'(2)) begin
            state_q <= txn_q ? ST_DONE : ST_GAP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (cnt_q == CW'(3)) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            txn_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          scl_q  <= 1'b1;
          sda_q  <= 1'b1;
          done_q <= 1'b1;
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign scl     = scl_q;
  assign sda_out = sda_q;
  assign done    = done_q;

endmodule

// File: tb/tb_i2c_init.sv
// tb_i2c_init: bench for i2c_init. Builds the expected bus waveform from
// the byte list and the I2C timing rules, compares every cycle, decodes
// the bus independently, and checks reset abort/restart and idle hold.
module tb_i2c_init;

  localparam int SU = 40;
`ifdef I2C_INIT_STARTUP_DELAY_EN
  localparam int D = SU;
`else
  localparam int D = 0;
`endif
  localparam int SEQ_CYC = 628;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl, sda_out, done;

  i2c_init #(.STARTUP_CYCLES(SU)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl    (scl),
    .sda_out(sda_out),
    .done   (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit exp_scl[$];
  bit exp_sda[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit c, input bit d);
    exp_scl.push_back(c);
    exp_sda.push_back(d);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 8; i >= 0; i--) begin
      bit v;
      v = (i == 0) ? 1'b1 : b[i-1];
      add(0, v); add(1, v); add(1, v); add(0, v);
    end
  endtask

  task automatic build_model();
    logic [7:0] t1 [14] = '{8'h20, 8'h00, 8'h36, 8'hAE, 8'h1C, 8'h01, 8'h22,
                            8'h22, 8'h30, 8'h30, 8'h30, 8'h30, 8'h22, 8'h00};
    logic [7:0] t2 [3]  = '{8'h20, 8'h00, 8'h37};
    repeat (D) add(1, 1);
    add(1, 1); add(1, 0); add(0, 0);
    foreach (t1[i]) add_byte(t1[i]);
    add(0, 0); add(1, 0); add(1, 1);
    repeat (4) add(1, 1);
    add(1, 1); add(1, 0); add(0, 0);
    foreach (t2[i]) add_byte(t2[i]);
    add(0, 0); add(1, 0); add(1, 1);
  endtask

  // Releases rst at the current negedge, then checks ncyc output cycles.
  task automatic run(input int ncyc, input bit full);
    int  exp_dec [19] = '{32'h20, 32'h00, 32'h36, 32'hAE, 32'h1C, 32'h01,
                          32'h22, 32'h22, 32'h30, 32'h30, 32'h30, 32'h30,
                          32'h22, 32'h00, 256, 32'h20, 32'h00, 32'h37, 256};
    int  dec[$];
    int  done_at = -1;
    int  starts = 0, stops = 0, ack_bad = 0, nbit = 0;
    logic pscl = 1'b1, psda = 1'b1;
    logic [7:0] sh = '0;
    int  first3 [3];
    rst = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      bit es, ed, edn;
      @(negedge clk);
      es  = (n < exp_scl.size()) ? exp_scl[n] : 1'b1;
      ed  = (n < exp_sda.size()) ? exp_sda[n] : 1'b1;
      edn = (n >= exp_scl.size());
      check($sformatf("trace@%0d {scl,sda,done}", n),
            int'({scl, sda_out, done}), int'({es, ed, edn}));
      if (n >= D && n < D + 3) first3[n-D] = int'({scl, sda_out});
      if (done && done_at < 0) done_at = n;
      if (pscl && scl && (sda_out != psda)) begin
        if (!sda_out) begin starts++; nbit = 0; end
        else begin stops++; dec.push_back(256); end
      end else if (!pscl && scl) begin
        if (nbit < 8) begin
          sh = {sh[6:0], sda_out};
          nbit++;
        end else begin
          if (!sda_out) ack_bad++;
          dec.push_back(int'(sh));
          nbit = 0;
        end
      end
      pscl = scl;
      psda = sda_out;
    end
    if (full) begin
      check("start_cycle0 {scl,sda}", first3[0], 3);
      check("start_cycle1 {scl,sda}", first3[1], 2);
      check("start_cycle2 {scl,sda}", first3[2], 0);
      check("start_count", starts, 2);
      check("stop_count", stops, 2);
      check("ack_slots_low", ack_bad, 0);
      check("decoded_len", dec.size(), 19);
      for (int i = 0; i < 19; i++)
        check($sformatf("decoded[%0d]", i), (i < dec.size()) ? dec[i] : -1, exp_dec[i]);
      check("done_cycle", done_at, D + 628);
    end
  endtask

  initial begin
    build_model();
    check("model_len", exp_scl.size(), D + SEQ_CYC);

    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset {scl,sda,done}", int'({scl, sda_out, done}), 6);
    end

    // Abort mid-byte: cycle D+202 is byte 5, bit 4, last phase (scl low).
    run(D + 203, 1'b0);
    check("pre_abort scl", int'(scl), 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort {scl,sda,done}", int'({scl, sda_out, done}), 6);
    @(negedge clk);
    check("abort_hold {scl,sda,done}", int'({scl, sda_out, done}), 6);

    // Full sequence from scratch, then 1000 idle cycles.
    run(D + SEQ_CYC + 1000, 1'b1);
    check("final {scl,sda,done}", int'({scl, sda_out, done}), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
